fetch_ras: RTL and testbench
============================

FETCH_RAS -- requirements
Module: fetch_ras

Interface
REQ-001 SHALL have parameter RAS_DEPTH, default 16, number of return-address entries (power of two).
REQ-002 SHALL have parameter PC_W, default 32, width of PC and return-address values.
REQ-003 SHALL have parameter INST_BYTES, default 8, PISA instruction size added to a call PC to form its return address.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port stall_i, input, 1, fetch stall; gates all speculative push/pop.
REQ-007 SHALL have port recoverFlag_i, input, 1, backend mispredict flush.
REQ-008 SHALL have port exceptionFlag_i, input, 1, exception flush; same effect as recoverFlag_i.
REQ-009 SHALL have port fs1Push_i, input, 1, fetch stage 1 BTB-hit call.
REQ-010 SHALL have port fs1Pop_i, input, 1, fetch stage 1 BTB-hit return.
REQ-011 SHALL have port fs1CallPC_i, input, PC_W, PC of the stage 1 call.
REQ-012 SHALL have port fs2MissedCall_i, input, 1, stage 2 BTB-missed call; push.
REQ-013 SHALL have port fs2MissedReturn_i, input, 1, stage 2 BTB-missed return; pop.
REQ-014 SHALL have port fs2CallPC_i, input, PC_W, PC of the stage 2 missed call.
REQ-015 SHALL have port commitPush_i, input, 1, a call retired this cycle.
REQ-016 SHALL have port commitPop_i, input, 1, a return retired this cycle.
REQ-017 SHALL have port addrRAS_o, output, PC_W, predicted return address at the speculative top of stack.
REQ-018 SHALL have port rasEmpty_o, output, 1, speculative valid count equals 0.
REQ-019 SHALL have port rasUnderflow_o, output, 1, one-cycle pulse when a pop is applied with count 0.

Function
REQ-020 SHALL hold storage mem[RAS_DEPTH], speculative specTos/specCnt, and committed commitTos/commitCnt; the pointers are log2(RAS_DEPTH) bits and the counts are log2(RAS_DEPTH)+1 bits.
REQ-021 SHALL drive addrRAS_o combinationally as mem[specTos] with zero-cycle latency, and drive rasEmpty_o as (specCnt==0).
REQ-022 SHALL select the action source each cycle with priority: flush (recoverFlag_i|exceptionFlag_i), then stage 2 (when ~stall_i), then stage 1 (when ~stall_i and no stage 2 action); lower-priority requests in that cycle are dropped.
REQ-023 SHALL, on flush, set specTos to the post-commit value of commitTos and specCnt to the post-commit value of commitCnt, and leave mem unchanged.
REQ-024 SHALL, on push (fs2MissedCall_i, or fs1Push_i), write mem[specTos+1] with the source call PC + INST_BYTES (modulo 2^PC_W), advance specTos by 1 modulo RAS_DEPTH, and saturate specCnt at RAS_DEPTH; at full, the oldest entry is overwritten.
REQ-025 SHALL, on pop (fs2MissedReturn_i, or fs1Pop_i), decrement specTos modulo RAS_DEPTH and decrement specCnt floored at 0; when specCnt is 0, the pointer still moves and rasUnderflow_o pulses for one cycle.
REQ-026 SHALL treat push and pop asserted together from the same source as a pop followed by a push: specTos is unchanged, mem[specTos] receives the new return address, and specCnt is unchanged, with a count of 0 becoming 1.
REQ-027 SHALL update commitTos/commitCnt by the same pointer and count rules on commitPush_i/commitPop_i, independent of stall_i; commitPush_i and commitPop_i together leave them unchanged.
REQ-028 SHALL keep the stage 2 pop value visible on addrRAS_o during the cycle fs2MissedReturn_i is asserted; the decrement takes effect at the next edge.

Reset
REQ-029 SHALL, while reset is low, asynchronously clear every mem entry, specTos, specCnt, commitTos and commitCnt to 0, giving addrRAS_o=0, rasEmpty_o=1 and rasUnderflow_o=0.
REQ-030 SHALL discard any in-flight push/pop when reset is asserted mid-operation, and SHALL accept no action on the first rising edge after reset deassertion unless inputs request one.

Verification
REQ-031 SHALL be verified by: fs1Push_i with fs1CallPC_i=0x1000, then fs1Pop_i -> addrRAS_o=0x1008 after the first edge, rasEmpty_o=1 after the second edge.
REQ-032 SHALL be verified by: 17 pushes with PCs 0x100*k for k=1..17 at RAS_DEPTH=16, then 16 pops -> first pop value 0x1108, rasEmpty_o=1 after the 16th pop, rasUnderflow_o never pulsing.
REQ-033 SHALL be verified by: a pop from empty -> rasUnderflow_o=1 for exactly one cycle and specCnt staying 0.
REQ-034 SHALL be verified by: fs2MissedCall_i (PC 0x2000) together with fs1Push_i (PC 0x3000) in one cycle -> only 0x2008 pushed.
REQ-035 SHALL be verified by: 3 speculative pushes and 1 commitPush_i, then recoverFlag_i -> specCnt=1 and addrRAS_o equal to the first pushed return address.
REQ-036 SHALL be verified by: stall_i=1 with fs1Push_i=1 -> no state change; recoverFlag_i together with commitPop_i -> restored state reflecting the pop.

Source files
------------

// File: rtl/fetch_ras.sv
// fetch_ras: return-address stack for the fetch unit.
// Holds a speculative top-of-stack/count pair updated by the fetch stages and
// a committed pair updated by retirement; a flush copies committed into
// speculative. Entries are never erased by a pop, so a flush can recover the
// committed view from the shared storage.
module fetch_ras #(
  parameter int RAS_DEPTH  = 16,
  parameter int PC_W       = 32,
  parameter int INST_BYTES = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            recoverFlag_i,
  input  logic            exceptionFlag_i,
  input  logic            fs1Push_i,
  input  logic            fs1Pop_i,
  input  logic [PC_W-1:0] fs1CallPC_i,
  input  logic            fs2MissedCall_i,
  input  logic            fs2MissedReturn_i,
  input  logic [PC_W-1:0] fs2CallPC_i,
  input  logic            commitPush_i,
  input  logic            commitPop_i,
  output logic [PC_W-1:0] addrRAS_o,
  output logic            rasEmpty_o,
  output logic            rasUnderflow_o
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] spec_tos_q, spec_tos_d;
  logic [CNT_W-1:0] spec_cnt_q, spec_cnt_d;
  logic [PTR_W-1:0] commit_tos_q, commit_tos_d;
  logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;
  logic             underflow_q, underflow_d;

  logic             flush;
  logic             s2_act;
  logic             s1_act;
  logic             push_sel;
  logic             pop_sel;
  logic [PC_W-1:0]  call_pc_sel;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [PC_W-1:0]  wr_data;

  // Committed pointer/count follow retirement; simultaneous push+pop cancels.
  always_comb begin
    commit_tos_d = commit_tos_q;
    commit_cnt_d = commit_cnt_q;
    if (commitPush_i && !commitPop_i) begin
      commit_tos_d = commit_tos_q + PTR_ONE;
      if (commit_cnt_q != CNT_FULL) commit_cnt_d = commit_cnt_q + CNT_ONE;
    end else if (commitPop_i && !commitPush_i) begin
      commit_tos_d = commit_tos_q - PTR_ONE;
      if (commit_cnt_q != '0) commit_cnt_d = commit_cnt_q - CNT_ONE;
    end
  end

  // Pick one action source: flush beats stage 2, stage 2 beats stage 1.
  always_comb begin
    flush       = recoverFlag_i | exceptionFlag_i;
    s2_act      = !flush && !stall_i && (fs2MissedCall_i || fs2MissedReturn_i);
    s1_act      = !flush && !stall_i && !s2_act && (fs1Push_i || fs1Pop_i);
    push_sel    = 1'b0;
    pop_sel     = 1'b0;
    call_pc_sel = fs1CallPC_i;
    if (s2_act) begin
      push_sel    = fs2MissedCall_i;
      pop_sel     = fs2MissedReturn_i;
      call_pc_sel = fs2CallPC_i;
    end else if (s1_act) begin
      push_sel = fs1Push_i;
      pop_sel  = fs1Pop_i;
    end
  end

  // Speculative pointer/count update and the storage write request.
  // A same-source push+pop replaces the top entry in place; it is not
  // reported as an underflow since the net stack depth does not shrink.
  always_comb begin
    spec_tos_d  = spec_tos_q;
    spec_cnt_d  = spec_cnt_q;
    underflow_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = spec_tos_q;
    wr_data     = call_pc_sel + PC_W'(INST_BYTES);
    if (flush) begin
      // Take the committed view including any retirement in this same cycle.
      spec_tos_d = commit_tos_d;
      spec_cnt_d = commit_cnt_d;
    end else if (push_sel && pop_sel) begin
      wr_en = 1'b1;
      if (spec_cnt_q == '0) spec_cnt_d = CNT_ONE;
    end else if (push_sel) begin
      wr_en      = 1'b1;
      wr_idx     = spec_tos_q + PTR_ONE;
      spec_tos_d = spec_tos_q + PTR_ONE;
      if (spec_cnt_q != CNT_FULL) spec_cnt_d = spec_cnt_q + CNT_ONE;
    end else if (pop_sel) begin
      spec_tos_d = spec_tos_q - PTR_ONE;
      if (spec_cnt_q == '0) underflow_d = 1'b1;
      else                  spec_cnt_d  = spec_cnt_q - CNT_ONE;
    end
  end

  // Pointer, count and underflow-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spec_tos_q   <= '0;
      spec_cnt_q   <= '0;
      commit_tos_q <= '0;
      commit_cnt_q <= '0;
      underflow_q  <= 1'b0;
    end else begin
      spec_tos_q   <= spec_tos_d;
      spec_cnt_q   <= spec_cnt_d;
      commit_tos_q <= commit_tos_d;
      commit_cnt_q <= commit_cnt_d;
      underflow_q  <= underflow_d;
    end
  end

  // Return-address storage; cleared on reset so the top reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign addrRAS_o      = mem_q[spec_tos_q];
  assign rasEmpty_o     = (spec_cnt_q == '0);
  assign rasUnderflow_o = underflow_q;

endmodule

// File: tb/tb_fetch_ras.sv
// tb_fetch_ras: vector table, directed corner sequences and random traffic
// checked against a stack-level reference model.
module tb_fetch_ras;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall, rec, exc, p1, o1, m2, r2, cp, co;
  logic [31:0] pc1, pc2;
  logic [31:0] addr;
  logic        empty, uf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a circular stack of return addresses with a
  // speculative and a committed (top, depth) view.
  logic [31:0] m_mem [D];
  int          m_stos, m_scnt, m_ctos, m_ccnt;
  bit          m_uf;

  typedef struct {
    bit          st, rc, ex, p1, o1;
    logic [31:0] pc1;
    bit          m2, r2;
    logic [31:0] pc2;
    bit          cp, co;
    logic [31:0] ea;
    bit          ee, eu;
  } vec_t;

  vec_t tbl [21];

  fetch_ras #(.RAS_DEPTH(D), .PC_W(32), .INST_BYTES(8)) dut (
    .clk               (clk),
    .reset             (reset_n),
    .stall_i           (stall),
    .recoverFlag_i     (rec),
    .exceptionFlag_i   (exc),
    .fs1Push_i         (p1),
    .fs1Pop_i          (o1),
    .fs1CallPC_i       (pc1),
    .fs2MissedCall_i   (m2),
    .fs2MissedReturn_i (r2),
    .fs2CallPC_i       (pc2),
    .commitPush_i      (cp),
    .commitPop_i       (co),
    .addrRAS_o         (addr),
    .rasEmpty_o        (empty),
    .rasUnderflow_o    (uf)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit st, bit rc, bit ex, bit a1, bit b1, logic [31:0] c1,
                              bit a2, bit b2, logic [31:0] c2, bit cpu, bit cpo,
                              logic [31:0] ea, bit ee, bit eu);
    vec_t v;
    v.st = st; v.rc = rc; v.ex = ex; v.p1 = a1; v.o1 = b1; v.pc1 = c1;
    v.m2 = a2; v.r2 = b2; v.pc2 = c2; v.cp = cpu; v.co = cpo;
    v.ea = ea; v.ee = ee; v.eu = eu;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; rec = 0; exc = 0; p1 = 0; o1 = 0; m2 = 0; r2 = 0; cp = 0; co = 0;
    pc1 = '0; pc2 = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_stos = 0; m_scnt = 0; m_ctos = 0; m_ccnt = 0; m_uf = 0;
  endtask

  task automatic model_apply(input bit push, input bit pop, input logic [31:0] pc);
    if (push && pop) begin
      m_mem[m_stos] = pc + 32'd8;
      if (m_scnt == 0) m_scnt = 1;
    end else if (push) begin
      m_stos = (m_stos + 1) % D;
      m_mem[m_stos] = pc + 32'd8;
      if (m_scnt < D) m_scnt++;
    end else begin
      if (m_scnt == 0) m_uf = 1;
      else m_scnt--;
      m_stos = (m_stos + D - 1) % D;
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int ct, cc;
    ct = m_ctos; cc = m_ccnt;
    if (cp && !co) begin
      ct = (ct + 1) % D;
      if (cc < D) cc++;
    end else if (co && !cp) begin
      ct = (ct + D - 1) % D;
      if (cc > 0) cc--;
    end
    m_uf = 0;
    if (rec || exc) begin
      m_stos = ct; m_scnt = cc;
    end else if (!stall && (m2 || r2)) begin
      model_apply(m2, r2, pc2);
    end else if (!stall && (p1 || o1)) begin
      model_apply(p1, o1, pc1);
    end
    m_ctos = ct; m_ccnt = cc;
  endtask

  // One clock with the current inputs; outputs compared 1ns after the edge.
  task automatic cycle(input string nm);
    @(posedge clk);
    model_step();
    #1;
    $display("[TB] txn %s addr=%h empty=%0d uf=%0d", nm, addr, empty, uf);
    check({nm, ":addr"},  addr, m_mem[m_stos]);
    check({nm, ":empty"}, {31'd0, empty}, {31'd0, (m_scnt == 0)});
    check({nm, ":uf"},    {31'd0, uf}, {31'd0, m_uf});
  endtask

  // Reset asserted mid-cycle with whatever inputs are active, held over an edge.
  task automatic do_reset(input string nm);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    $display("[TB] txn %s reset addr=%h empty=%0d uf=%0d", nm, addr, empty, uf);
    check({nm, ":rst_addr"},  addr, 32'h0);
    check({nm, ":rst_empty"}, {31'd0, empty}, 32'd1);
    check({nm, ":rst_uf"},    {31'd0, uf}, 32'd0);
    @(posedge clk);
    #1;
    clear_inputs();
    reset_n = 1'b1;
  endtask

  task automatic push1(input logic [31:0] pc, input string nm);
    clear_inputs(); p1 = 1; pc1 = pc;
    cycle(nm);
  endtask

  task automatic pop1(input string nm);
    clear_inputs(); o1 = 1;
    cycle(nm);
  endtask

  initial begin
    bit any_uf;
    clear_inputs();
    model_reset();
    #1;
    // Table: starts from reset and walks push/pop/stall/priority/flush cases.
    tbl[0]  = mk(0,0,0, 0,0,32'h0,    0,0,32'h0,    0,0, 32'h0,    1,0);
    tbl[1]  = mk(0,0,0, 1,0,32'h1000, 0,0,32'h0,    0,0, 32'h1008, 0,0);
    tbl[2]  = mk(0,0,0, 0,1,32'h0,    0,0,32'h0,    0,0, 32'h0,    1,0);
    tbl[3]  = mk(0,0,0, 1,0,32'h3000, 1,0,32'h2000, 0,0, 32'h2008, 0,0);
    tbl[4]  = mk(1,0,0, 1,0,32'h4000, 0,0,32'h0,    0,0, 32'h2008, 0,0);
    tbl[5]  = mk(1,0,0, 0,1,32'h0,    0,0,32'h0,    0,0, 32'h2008, 0,0);
    tbl[6]  = mk(0,0,0, 1,1,32'h5000, 0,0,32'h0,    0,0, 32'h5008, 0,0);
    tbl[7]  = mk(0,0,0, 1,0,32'h6000, 0,1,32'h0,    0,0, 32'h0,    1,0);
    tbl[8]  = mk(0,0,0, 0,1,32'h0,    0,0,32'h0,    0,0, 32'h0,    1,1);
    tbl[9]  = mk(0,0,0, 0,0,32'h0,    0,0,32'h0,    0,0, 32'h0,    1,0);
    tbl[10] = mk(0,1,0, 0,0,32'h0,    0,0,32'h0,    0,0, 32'h0,    1,0);
    tbl[11] = mk(0,0,0, 1,0,32'h7000, 0,0,32'h0,    0,0, 32'h7008, 0,0);
    tbl[12] = mk(0,0,1, 0,0,32'h0,    0,0,32'h0,    0,0, 32'h0,    1,0);
    tbl[13] = mk(0,0,0, 0,0,32'h0,    1,1,32'h8000, 0,0, 32'h8008, 0,0);
    tbl[14] = mk(0,0,0, 0,1,32'h0,    0,0,32'h0,    0,0, 32'h0,    1,0);
    tbl[15] = mk(0,0,0, 1,0,32'h9000, 0,0,32'h0,    1,0, 32'h9008, 0,0);
    tbl[16] = mk(0,0,0, 0,0,32'h0,    0,0,32'h0,    1,0, 32'h9008, 0,0);
    tbl[17] = mk(0,1,0, 0,0,32'h0,    0,0,32'h0,    0,1, 32'h7008, 0,0);
    tbl[18] = mk(0,0,0, 0,0,32'h0,    0,0,32'h0,    1,1, 32'h7008, 0,0);
    tbl[19] = mk(0,1,0, 1,0,32'hA000, 0,0,32'h0,    0,0, 32'h7008, 0,0);
    tbl[20] = mk(0,0,0, 0,1,32'h0,    0,0,32'h0,    0,0, 32'h9008, 1,0);

    do_reset("init");
    for (int i = 0; i < 21; i++) begin
      stall = tbl[i].st; rec = tbl[i].rc; exc = tbl[i].ex;
      p1 = tbl[i].p1; o1 = tbl[i].o1; pc1 = tbl[i].pc1;
      m2 = tbl[i].m2; r2 = tbl[i].r2; pc2 = tbl[i].pc2;
      cp = tbl[i].cp; co = tbl[i].co;
      cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d:tbl_addr", i),  addr, tbl[i].ea);
      check($sformatf("vec%0d:tbl_empty", i), {31'd0, empty}, {31'd0, tbl[i].ee});
      check($sformatf("vec%0d:tbl_uf", i),    {31'd0, uf}, {31'd0, tbl[i].eu});
    end

    // Overflow: 17 pushes into 16 entries, then drain 16 without underflow.
    do_reset("ovf");
    for (int k = 1; k <= 17; k++) push1(32'h100 * k, $sformatf("ovf_push%0d", k));
    check("ovf:first_pop_val", addr, 32'h1108);
    any_uf = 0;
    for (int k = 1; k <= 16; k++) begin
      pop1($sformatf("ovf_pop%0d", k));
      if (uf) any_uf = 1;
    end
    check("ovf:empty_after_16", {31'd0, empty}, 32'd1);
    check("ovf:no_underflow", {31'd0, any_uf}, 32'd0);

    // Pop from empty: one-cycle underflow pulse, count stays at zero.
    do_reset("udf");
    pop1("udf_pop");
    check("udf:pulse", {31'd0, uf}, 32'd1);
    clear_inputs();
    cycle("udf_idle");
    check("udf:pulse_gone", {31'd0, uf}, 32'd0);
    push1(32'h40, "udf_push");
    pop1("udf_pop2");
    check("udf:cnt_was_zero", {31'd0, empty}, 32'd1);

    // Stage-2 pop value stays on the output until the edge.
    do_reset("s2pop");
    push1(32'hA0, "s2pop_pushA");
    push1(32'hB0, "s2pop_pushB");
    clear_inputs(); r2 = 1;
    #1;
    check("s2pop:before_edge", addr, 32'hB8);
    cycle("s2pop_pop");
    check("s2pop:after_edge", addr, 32'hA8);

    // Three speculative pushes, one retired, then recover.
    do_reset("rcv");
    clear_inputs(); p1 = 1; pc1 = 32'h100; cp = 1;
    cycle("rcv_push1_commit");
    push1(32'h200, "rcv_push2");
    push1(32'h300, "rcv_push3");
    clear_inputs(); rec = 1;
    cycle("rcv_flush");
    check("rcv:addr", addr, 32'h108);
    check("rcv:not_empty", {31'd0, empty}, 32'd0);
    pop1("rcv_pop");
    check("rcv:cnt_one", {31'd0, empty}, 32'd1);

    // Reset arriving while a push is being requested discards it.
    push1(32'h500, "midrst_pre");
    clear_inputs(); p1 = 1; pc1 = 32'hDEAD0000;
    do_reset("midrst");
    cycle("midrst_first_edge");
    check("midrst:addr", addr, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 5) == 0);
      rec   = ($urandom_range(0, 19) == 0);
      exc   = ($urandom_range(0, 39) == 0);
      p1    = ($urandom_range(0, 2) == 0);
      o1    = ($urandom_range(0, 3) == 0);
      pc1   = $urandom;
      m2    = ($urandom_range(0, 6) == 0);
      r2    = ($urandom_range(0, 7) == 0);
      pc2   = $urandom;
      cp    = ($urandom_range(0, 4) == 0);
      co    = ($urandom_range(0, 5) == 0);
      cycle($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
